// File: rtl/dsp_pkg.sv
// Shared constants for the DSP datapath blocks: slice width, add/sub encodings,
// width limits and the slice-count macro used to size carry-pipelined adders.
`ifndef DSP_N_SLICES
`define DSP_N_SLICES(w) ((w) / 16)
`endif

package dsp_pkg;

  localparam int   SLICE_W    = 16;
  localparam int   MAX_WIDTH  = 128;
  localparam logic ADDSUB_ADD = 1'b0;
  localparam logic ADDSUB_SUB = 1'b1;

  function automatic int n_slices(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/dsp_addsub_slice.sv
// One 16-bit add/subtract slice: {cout, sum} = a + b' + cin, with b' = sub ? ~b : b.
// DSP_ADDSUB_SB_MAC16_EN selects an SB_MAC16 adder half instead of fabric carry logic.
module dsp_addsub_slice
  import dsp_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               sub_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o,
  output logic               msb_a_o,
  output logic               msb_b_o
);

  logic [SLICE_W-1:0] b_eff;

  assign b_eff   = (sub_i == ADDSUB_SUB) ? ~b_i : b_i;
  assign msb_a_o = a_i[SLICE_W-1];
  assign msb_b_o = b_eff[SLICE_W-1];

`ifdef DSP_ADDSUB_SB_MAC16_EN
  logic [31:0] mac_o;

  // Bottom adder does D +/- B + CI; the top adder adds zeros plus the bottom
  // carry so the slice carry-out appears on O[16].
  SB_MAC16 #(
    .NEG_TRIGGER              (1'b0),
    .C_REG                    (1'b0),
    .A_REG                    (1'b0),
    .B_REG                    (1'b0),
    .D_REG                    (1'b0),
    .TOP_8x8_MULT_REG         (1'b0),
    .BOT_8x8_MULT_REG         (1'b0),
    .PIPELINE_16x16_MULT_REG1 (1'b0),
    .PIPELINE_16x16_MULT_REG2 (1'b0),
    .TOPOUTPUT_SELECT         (2'b00),
    .TOPADDSUB_LOWERINPUT     (2'b00),
    .TOPADDSUB_UPPERINPUT     (1'b1),
    .TOPADDSUB_CARRYSELECT    (2'b10),
    .BOTOUTPUT_SELECT         (2'b00),
    .BOTADDSUB_LOWERINPUT     (2'b00),
    .BOTADDSUB_UPPERINPUT     (1'b1),
    .BOTADDSUB_CARRYSELECT    (2'b11),
    .MODE_8x8                 (1'b0),
    .A_SIGNED                 (1'b0),
    .B_SIGNED                 (1'b0)
  ) u_mac (
    .CLK        (1'b0),
    .CE         (1'b1),
    .C          (16'h0000),
    .A          (16'h0000),
    .B          (b_i),
    .D          (a_i),
    .AHOLD      (1'b0),
    .BHOLD      (1'b0),
    .CHOLD      (1'b0),
    .DHOLD      (1'b0),
    .IRSTTOP    (1'b0),
    .IRSTBOT    (1'b0),
    .ORSTTOP    (1'b0),
    .ORSTBOT    (1'b0),
    .OLOADTOP   (1'b0),
    .OLOADBOT   (1'b0),
    .ADDSUBTOP  (1'b0),
    .ADDSUBBOT  (sub_i),
    .OHOLDTOP   (1'b0),
    .OHOLDBOT   (1'b0),
    .CI         (cin_i),
    .ACCUMCI    (1'b0),
    .SIGNEXTIN  (1'b0),
    .O          (mac_o),
    .CO         (),
    .ACCUMCO    (),
    .SIGNEXTOUT ()
  );

  assign sum_o  = mac_o[SLICE_W-1:0];
  assign cout_o = mac_o[SLICE_W];
`else
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, cin_i};
`endif

endmodule

// File: rtl/dsp_addsub_pipe.sv
// Carry-pipelined WIDTH-bit add/subtract: one 16-bit slice resolved per stage, full-pipeline stall.
// Slice implementation chosen by DSP_ADDSUB_SB_MAC16_EN (see dsp_addsub_slice).
module dsp_addsub_pipe
  import dsp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int N = `DSP_N_SLICES(WIDTH);

  logic             adv;
  logic [N-1:0]     vld_q;
  logic [N-1:0]     carry_q;
  logic [WIDTH-1:0] a_q   [N];
  logic [WIDTH-1:0] b_q   [N];
  logic [WIDTH-1:0] res_q [N];
  logic [TAG_W-1:0] tag_q [N];
  logic             sub_q [N];
  logic             ovf_q, zero_q;

  logic [N-1:0]       vld_in, cin, cout;
  logic [WIDTH-1:0]   a_in   [N];
  logic [WIDTH-1:0]   b_in   [N];
  logic [WIDTH-1:0]   res_in [N];
  logic [WIDTH-1:0]   res_d  [N];
  logic [TAG_W-1:0]   tag_in [N];
  logic               sub_in [N];
  logic [SLICE_W-1:0] sum    [N];
  logic               msb_a  [N];
  logic               msb_b  [N];
  logic               ovf_d;

  // Bubbles advance with real ops; only a held output result freezes the pipe.
  assign adv      = ~(out_valid & ~out_ready);
  assign in_ready = adv;

  for (genvar k = 0; k < N; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vld_in[0] = in_valid;
      assign a_in[0]   = in_a;
      assign b_in[0]   = in_b;
      assign sub_in[0] = in_sub;
      assign tag_in[0] = in_tag;
      assign cin[0]    = in_sub;
      assign res_in[0] = '0;
    end else begin : g_body
      assign vld_in[k] = vld_q[k-1];
      assign a_in[k]   = a_q[k-1];
      assign b_in[k]   = b_q[k-1];
      assign sub_in[k] = sub_q[k-1];
      assign tag_in[k] = tag_q[k-1];
      assign cin[k]    = carry_q[k-1];
      assign res_in[k] = res_q[k-1];
    end

    dsp_addsub_slice u_slice (
      .a_i     (a_in[k][k*SLICE_W +: SLICE_W]),
      .b_i     (b_in[k][k*SLICE_W +: SLICE_W]),
      .sub_i   (sub_in[k]),
      .cin_i   (cin[k]),
      .sum_o   (sum[k]),
      .cout_o  (cout[k]),
      .msb_a_o (msb_a[k]),
      .msb_b_o (msb_b[k])
    );

    assign res_d[k] = res_in[k] | (WIDTH'(sum[k]) << (k * SLICE_W));
  end

  assign ovf_d = (msb_a[N-1] == msb_b[N-1]) & (sum[N-1][SLICE_W-1] != msb_a[N-1]);

  // Stage boundary: valid, resolved result slices, tag, inter-slice carry and final flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        res_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q   <= vld_in;
      carry_q <= cout;
      ovf_q   <= ovf_d;
      zero_q  <= (res_d[N-1] == '0);
      for (int k = 0; k < N; k++) begin
        res_q[k] <= res_d[k];
        tag_q[k] <= tag_in[k];
      end
    end
  end

  // Stage boundary: operands skewed forward so stage k sees its own slice.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int k = 0; k < N; k++) begin
        a_q[k]   <= a_in[k];
        b_q[k]   <= b_in[k];
        sub_q[k] <= sub_in[k];
      end
    end
  end

  assign out_valid = vld_q[N-1];
  assign out_data  = res_q[N-1];
  assign out_tag   = tag_q[N-1];
  assign out_carry = carry_q[N-1];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_dsp_addsub_pipe.sv
// Randomized and directed checks of dsp_addsub_pipe at WIDTH=32 and WIDTH=64 against a queue-based model.
module tb_dsp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  in_valid, out_ready;
  logic [63:0] in_a, in_b;
  logic        in_sub;
  logic [3:0]  in_tag;

  logic        ir32, ov32, oc32, oo32, oz32;
  logic [31:0] od32;
  logic [3:0]  ot32;
  logic        ir64, ov64, oc64, oo64, oz64;
  logic [63:0] od64;
  logic [3:0]  ot64;

  always #5 clk = ~clk;

  dsp_addsub_pipe #(.WIDTH(32), .TAG_W(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(ir32),
    .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready[0]), .out_data(od32), .out_tag(ot32),
    .out_carry(oc32), .out_ovf(oo32), .out_zero(oz32)
  );

  dsp_addsub_pipe #(.WIDTH(64), .TAG_W(4)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(ir64),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready[1]), .out_data(od64), .out_tag(ot64),
    .out_carry(oc64), .out_ovf(oo64), .out_zero(oz64)
  );

  typedef struct {
    logic [63:0] r;
    logic [3:0]  tag;
    bit          c, o, z;
    int          age;
  } exp_t;

  exp_t        q[$];
  logic [3:0]  out_tags[$];
  int          n_cmp = 0, n_bad = 0, n_out = 0;
  int          sel = 0;
  bit          prev_stall = 0, last_acc = 0;
  logic [70:0] prev_bus = '0;
  logic        s_ov, s_ir, s_oc, s_oo, s_oz;
  logic [63:0] s_od;
  logic [3:0]  s_ot;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the definition of add/sub at width w.
  function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b, input bit sub,
                                output logic [63:0] r, output bit c, output bit o, output bit z);
    logic [64:0] full;
    logic [63:0] mask, am, bm;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bm   = b & mask;
    full = sub ? ({1'b0, am} + {1'b0, ~bm & mask} + 65'd1) : ({1'b0, am} + {1'b0, bm});
    r    = full[63:0] & mask;
    c    = full[w];
    if (sub) o = (am[w-1] != bm[w-1]) && (r[w-1] != am[w-1]);
    else     o = (am[w-1] == bm[w-1]) && (r[w-1] != am[w-1]);
    z    = (r == 64'd0);
  endfunction

  function automatic logic [63:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_8000_0000;
      3:       return 64'h7FFF_FFFF_7FFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic sample();
    if (sel == 0) begin
      s_ov = ov32; s_ir = ir32; s_od = {32'd0, od32}; s_ot = ot32;
      s_oc = oc32; s_oo = oo32; s_oz = oz32;
    end else begin
      s_ov = ov64; s_ir = ir64; s_od = od64; s_ot = ot64;
      s_oc = oc64; s_oo = oo64; s_oz = oz64;
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input bit iv, input logic [63:0] a, input logic [63:0] b, input bit sub,
                      input logic [3:0] tag, input bit ordy);
    int          w, n;
    bit          exp_v, stall;
    exp_t        e;
    logic [70:0] bus;
    w = (sel == 0) ? 32 : 64;
    n = w / 16;
    in_valid = 2'b00;
    in_valid[sel] = iv;
    out_ready = 2'b11;
    out_ready[sel] = ordy;
    in_a = a; in_b = b; in_sub = sub; in_tag = tag;
    #1;
    sample();
    exp_v = (q.size() > 0) && (q[0].age >= n);
    check("out_valid", s_ov, exp_v);
    check("in_ready", s_ir, !(exp_v && !ordy));
    bus = {s_od, s_ot, s_oc, s_oo, s_oz};
    if (prev_stall) check("hold_while_stalled", bus, prev_bus);
    if (exp_v && s_ov) begin
      check("out_data", s_od, q[0].r);
      check("out_tag", s_ot, q[0].tag);
      check("flags_c_o_z", {s_oc, s_oo, s_oz}, {q[0].c, q[0].o, q[0].z});
    end
    if (s_ov && ordy) out_tags.push_back(s_ot);
    stall      = exp_v && !ordy;
    last_acc   = iv && !stall;
    prev_stall = stall;
    prev_bus   = bus;
    @(posedge clk);
    if (!stall) begin
      if (exp_v) begin
        void'(q.pop_front());
        n_out++;
      end
      for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
    end
    if (last_acc) begin
      model(w, a, b, sub, e.r, e.c, e.o, e.z);
      e.tag = tag;
      e.age = 1;
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 64'd0, 64'd0, 1'b0, 4'd0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) idle();
    check("drain_empty", q.size(), 0);
  endtask

  task automatic rand_run(input int cycles);
    for (int i = 0; i < cycles; i++)
      step($urandom_range(0, 9) < 7, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)),
           4'($urandom), $urandom_range(0, 3) != 0);
    drain();
  endtask

  // Single op followed by idles; checks latency and literal result fields.
  task automatic directed(input string name, input logic [63:0] a, input logic [63:0] b, input bit sub,
                          input logic [3:0] tag, input logic [63:0] exp_d, input logic [2:0] exp_f);
    int n;
    n = (sel == 0) ? 2 : 4;
    step(1'b1, a, b, sub, tag, 1'b1);
    for (int i = 1; i < n; i++) begin
      idle();
      check({name, "_early"}, s_ov, 1'b0);
    end
    idle();
    check({name, "_valid"}, s_ov, 1'b1);
    check({name, "_data"}, s_od, exp_d);
    check({name, "_flags"}, {s_oc, s_oo, s_oz}, exp_f);
    check({name, "_tag"}, s_ot, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt, stalls, base;
    bit ordy;
    rst_n = 1'b0;
    in_valid = 2'b00; out_ready = 2'b11;
    in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {ov32, ov64}, 2'b00);
    check("rst_out_bus", {od32, ot32, oc32, oo32, oz32, od64, ot64, oc64, oo64, oz64}, 0);
    check("rst_in_ready", {ir32, ir64}, 2'b11);
    rst_n = 1'b1;
    @(negedge clk);

    // WIDTH=32 directed cases
    sel = 0;
    directed("t1_carry_ripple", 64'h0000FFFF, 64'h1, 1'b0, 4'h3, 64'h00010000, 3'b000);
    directed("t2_borrow",       64'h00000000, 64'h1, 1'b1, 4'h1, 64'hFFFFFFFF, 3'b000);
    directed("t2_sub_ovf",      64'h80000000, 64'h1, 1'b1, 4'h2, 64'h7FFFFFFF, 3'b110);
    directed("t3_add_ovf",      64'h7FFFFFFF, 64'h1, 1'b0, 4'hA, 64'h80000000, 3'b010);
    directed("t3_sub_zero",     64'h00000005, 64'h5, 1'b1, 4'h6, 64'h00000000, 3'b101);

    // Back-pressure mid-stream with 8 back-to-back ops
    out_tags.delete();
    base = n_out; nxt = 0; stalls = 0;
    for (int c = 0; c < 40 && (nxt < 8 || q.size() > 0); c++) begin
      ordy = !(c >= 3 && c <= 5);
      step(nxt < 8, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 4'(nxt), ordy);
      if (!s_ir) stalls++;
      if (last_acc) nxt++;
    end
    check("t4_stall_cycles", stalls, 3);
    check("t4_result_count", n_out - base, 8);
    check("t4_tags_seen", out_tags.size(), 8);
    for (int i = 0; i < out_tags.size() && i < 8; i++) check("t4_tag_order", out_tags[i], i);

    // Reset with two ops in flight
    step(1'b1, 64'h1111, 64'h2222, 1'b0, 4'h1, 1'b1);
    step(1'b1, 64'h3333, 64'h4444, 1'b0, 4'h2, 1'b1);
    in_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", ov32, 1'b0);
    check("t5_rst_in_ready", ir32, 1'b1);
    q.delete();
    prev_stall = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) idle();
    directed("t5_after_reset", 64'h12345678, 64'h11111111, 1'b1, 4'h9, 64'h01234567, 3'b100);

    rand_run(300);

    // WIDTH=64
    sel = 1;
    prev_stall = 0;
    directed("t6_wrap64", '1, 64'h1, 1'b0, 4'h5, 64'h0, 3'b101);
    directed("t6_sub64", 64'h0000_0001_0000_0000, 64'h1, 1'b1, 4'h4, 64'h0000_0000_FFFF_FFFF, 3'b100);
    rand_run(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
